tfhe_pbs_sequencer: RTL and testbench

//  Job sequencer directly downstream of the AXI-lite TFHE control register block: consumes start_pbs, hbm_select, host_wr_addr/len.

---
 rtl/tfhe_dma_pkg.sv | 22 ++
 rtl/tfhe_pbs_sequencer_if.sv | 28 ++
 rtl/tfhe_burst_splitter.sv | 27 ++
 rtl/tfhe_pbs_sequencer.sv | 137 +++++++++++++
 tb/tb_tfhe_pbs_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tfhe_dma_pkg.sv
// Shared types and helpers for the TFHE PBS job sequencer and its burst splitter.
// Holds the FSM state encoding, the host page size and the page-room helper.
package tfhe_dma_pkg;

   localparam int PAGE_BYTES = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_RUN,
      ST_CMD,
      ST_WAIT,
      ST_DONE,
      ST_ERR
   } seq_state_t;

   // Bytes left before the next 4 KiB boundary; always 1..4096.
   function automatic logic [12:0] page_room(input logic [11:0] offset);
      return 13'(PAGE_BYTES) - {1'b0, offset};
   endfunction

endpackage

// File: rtl/tfhe_pbs_sequencer_if.sv
// Write-DMA command channel between the PBS sequencer (master) and the DMA engine (slave).
interface tfhe_pbs_sequencer_if #(
   parameter int DW = 32
) ();

   logic          wr_cmd_valid;
   logic          wr_cmd_ready;
   logic [DW-1:0] wr_cmd_addr;
   logic [DW-1:0] wr_cmd_len;
   logic          wr_done;

   modport master (
      output wr_cmd_valid,
      output wr_cmd_addr,
      output wr_cmd_len,
      input  wr_cmd_ready,
      input  wr_done
   );

   modport slave (
      input  wr_cmd_valid,
      input  wr_cmd_addr,
      input  wr_cmd_len,
      output wr_cmd_ready,
      output wr_done
   );

endinterface

// File: rtl/tfhe_burst_splitter.sv
// Combinational burst sizing: the next burst never crosses a 4 KiB page and never
// exceeds MAX_BURST_BYTES; also returns the address/remaining count after that burst.
module tfhe_burst_splitter
   import tfhe_dma_pkg::*;
#(
   parameter int DW              = 32,
   parameter int MAX_BURST_BYTES = 4096
) (
   input  logic [DW-1:0] addr,
   input  logic [DW-1:0] rem,
   output logic [DW-1:0] burst,
   output logic [DW-1:0] next_addr,
   output logic [DW-1:0] next_rem
);

   logic [DW-1:0] room;
   logic [DW-1:0] cap;

   always_comb begin
      room      = DW'(page_room(addr[11:0]));
      cap       = (room < DW'(MAX_BURST_BYTES)) ? room : DW'(MAX_BURST_BYTES);
      burst     = (rem < cap) ? rem : cap;
      next_addr = addr + burst;
      next_rem  = rem - burst;
   end

endmodule

// File: rtl/tfhe_pbs_sequencer.sv
// PBS job sequencer: launches the PBS core, waits for completion, then streams the result
// to host memory as page-safe write-DMA bursts. Optional watchdog: define TFHE_SEQ_TIMEOUT_EN.
module tfhe_pbs_sequencer
   import tfhe_dma_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int MAX_BURST_BYTES    = 4096,
   parameter int TIMEOUT_CYCLES     = 2**24
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   input  logic                          start_pbs,
   input  logic [1:0]                    hbm_select,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] host_wr_addr,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] host_wr_len,
   output logic                          core_start,
   output logic [1:0]                    core_bank,
   input  logic                          core_done,
   tfhe_pbs_sequencer_if.master          dma,
   output logic                          pbs_busy,
   output logic                          pbs_done,
   output logic                          pbs_err,
   output logic [C_S_AXI_DATA_WIDTH-1:0] host_rd_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] host_rd_len
);

   localparam int DW = C_S_AXI_DATA_WIDTH;

   if (TIMEOUT_CYCLES < 1 || MAX_BURST_BYTES < 1 || MAX_BURST_BYTES > PAGE_BYTES ||
       (MAX_BURST_BYTES & (MAX_BURST_BYTES - 1)) != 0) begin : g_bad_params
      $error("tfhe_pbs_sequencer: illegal TIMEOUT_CYCLES or MAX_BURST_BYTES");
   end

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic          start_q;
   logic          start_rise;
   logic          abort_q;
   logic [DW-1:0] burst;
   logic [DW-1:0] next_addr;
   logic [DW-1:0] next_rem;

   tfhe_burst_splitter #(
      .DW              (DW),
      .MAX_BURST_BYTES (MAX_BURST_BYTES)
   ) u_splitter (
      .addr      (host_rd_addr),
      .rem       (host_rd_len),
      .burst     (burst),
      .next_addr (next_addr),
      .next_rem  (next_rem)
   );

`ifdef TFHE_SEQ_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        wd_expired;

   assign wd_expired = (state == ST_RUN || state == ST_WAIT) &&
                       (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET)
         wd_cnt <= '0;
      else if (state_nxt != state)
         wd_cnt <= '0;
      else if (state == ST_RUN || state == ST_WAIT)
         wd_cnt <= wd_cnt + 32'd1;
   end
`endif

   // start_q resets high so a start level already present when reset lifts is not an edge.
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         state        <= ST_IDLE;
         start_q      <= 1'b1;
         start_rise   <= 1'b0;
         abort_q      <= 1'b0;
         core_bank    <= '0;
         host_rd_addr <= '0;
         host_rd_len  <= '0;
      end else begin
         state      <= state_nxt;
         start_q    <= start_pbs;
         start_rise <= start_pbs & ~start_q;
         abort_q    <= (abort_q || !start_pbs) &&
                       (state_nxt == ST_CMD || state_nxt == ST_WAIT);
         if (state == ST_IDLE && start_rise) begin
            core_bank    <= hbm_select;
            host_rd_addr <= host_wr_addr;
            host_rd_len  <= host_wr_len;
         end else if (state == ST_WAIT && dma.wr_done) begin
            host_rd_addr <= next_addr;
            host_rd_len  <= next_rem;
         end
      end
   end

   // An abort raised during a burst is remembered and honoured only once that burst is written.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start_rise) state_nxt = ST_LAUNCH;
         ST_LAUNCH: state_nxt = start_pbs ? ST_RUN : ST_ERR;
         ST_RUN: begin
            if (!start_pbs)
               state_nxt = ST_ERR;
            else if (core_done)
               state_nxt = (host_rd_len == '0) ? ST_DONE : ST_CMD;
         end
         ST_CMD:    if (dma.wr_cmd_ready) state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (dma.wr_done) begin
               if (abort_q || !start_pbs)
                  state_nxt = ST_ERR;
               else
                  state_nxt = (next_rem == '0) ? ST_DONE : ST_CMD;
            end
         end
         ST_DONE,
         ST_ERR:    if (!start_pbs) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
`ifdef TFHE_SEQ_TIMEOUT_EN
      if (wd_expired) state_nxt = ST_ERR;
`endif
   end

   assign core_start       = (state == ST_LAUNCH);
   assign pbs_busy         = (state == ST_LAUNCH) || (state == ST_RUN) ||
                             (state == ST_CMD)    || (state == ST_WAIT);
   assign pbs_done         = (state == ST_DONE);
   assign pbs_err          = (state == ST_ERR);
   assign dma.wr_cmd_valid = (state == ST_CMD);
   assign dma.wr_cmd_addr  = host_rd_addr;
   assign dma.wr_cmd_len   = burst;

endmodule

// File: tb/tb_tfhe_pbs_sequencer.sv
// Self-checking bench for tfhe_pbs_sequencer: directed corner cases plus randomized jobs
// checked against a burst-list model. Timeout expectations follow TFHE_SEQ_TIMEOUT_EN.
module tb_tfhe_pbs_sequencer;

   localparam int          DW        = 32;
   localparam int unsigned MAX_BURST = 4096;
   localparam int          TIMEOUT   = 100;

   logic          S_AXI_ACLK = 1'b0;
   logic          S_AXI_ARESET = 1'b1;
   logic          start_pbs = 1'b1;
   logic [1:0]    hbm_select = 2'd0;
   logic [DW-1:0] host_wr_addr = '0;
   logic [DW-1:0] host_wr_len = '0;
   logic          core_start;
   logic [1:0]    core_bank;
   logic          core_done = 1'b0;
   logic          pbs_busy;
   logic          pbs_done;
   logic          pbs_err;
   logic [DW-1:0] host_rd_addr;
   logic [DW-1:0] host_rd_len;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] expAddr[$];
   logic [31:0] expLen[$];

   tfhe_pbs_sequencer_if #(.DW(DW)) dma ();

   tfhe_pbs_sequencer #(
      .C_S_AXI_DATA_WIDTH (DW),
      .MAX_BURST_BYTES    (MAX_BURST),
      .TIMEOUT_CYCLES     (TIMEOUT)
   ) dut (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESET (S_AXI_ARESET),
      .start_pbs    (start_pbs),
      .hbm_select   (hbm_select),
      .host_wr_addr (host_wr_addr),
      .host_wr_len  (host_wr_len),
      .core_start   (core_start),
      .core_bank    (core_bank),
      .core_done    (core_done),
      .dma          (dma),
      .pbs_busy     (pbs_busy),
      .pbs_done     (pbs_done),
      .pbs_err      (pbs_err),
      .host_rd_addr (host_rd_addr),
      .host_rd_len  (host_rd_len)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation did not finish, errors so far %0d", errorCount);
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
      end
   endtask

   // All DUT outputs come from registers, so sampling 1 time unit after the edge is safe.
   task automatic stepCycle();
      @(posedge S_AXI_ACLK);
      #1;
   endtask

   task automatic buildModel(input logic [31:0] a, input logic [31:0] l);
      logic [31:0] addr;
      logic [31:0] rem;
      int unsigned room;
      int unsigned b;
      expAddr.delete();
      expLen.delete();
      addr = a;
      rem  = l;
      while (rem != 0) begin
         room = 4096 - (addr % 4096);
         b    = rem;
         if (b > MAX_BURST) b = MAX_BURST;
         if (b > room)      b = room;
         expAddr.push_back(addr);
         expLen.push_back(b);
         addr = addr + b;
         rem  = rem - b;
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_core_start"}, core_start, 0);
      checkOutput({tag, "_core_bank"}, core_bank, 0);
      checkOutput({tag, "_valid"}, dma.wr_cmd_valid, 0);
      checkOutput({tag, "_cmd_addr"}, dma.wr_cmd_addr, 0);
      checkOutput({tag, "_cmd_len"}, dma.wr_cmd_len, 0);
      checkOutput({tag, "_busy"}, pbs_busy, 0);
      checkOutput({tag, "_done"}, pbs_done, 0);
      checkOutput({tag, "_err"}, pbs_err, 0);
      checkOutput({tag, "_rd_addr"}, host_rd_addr, 0);
      checkOutput({tag, "_rd_len"}, host_rd_len, 0);
   endtask

   // Raises start and checks the two-cycle launch latency; returns with the DUT in RUN.
   task automatic launchJob(input logic [31:0] a, input logic [31:0] l, input logic [1:0] bank);
      host_wr_addr = a;
      host_wr_len  = l;
      hbm_select   = bank;
      start_pbs    = 1'b1;
      stepCycle();
      checkOutput("launch_early", core_start, 0);
      stepCycle();
      checkOutput("launch_pulse", core_start, 1);
      checkOutput("launch_busy", pbs_busy, 1);
      checkOutput("launch_bank", core_bank, bank);
      checkOutput("launch_rd_addr", host_rd_addr, a);
      checkOutput("launch_rd_len", host_rd_len, l);
      hbm_select   = ~bank;
      host_wr_addr = ~a;
      host_wr_len  = ~l;
      stepCycle();
      checkOutput("run_core_start", core_start, 0);
      checkOutput("run_busy", pbs_busy, 1);
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] l, input logic [1:0] bank);
      logic [31:0] ma;
      logic [31:0] ml;
      buildModel(a, l);
      launchJob(a, l, bank);
      repeat ($urandom_range(0, 4)) stepCycle();
      core_done = 1'b1;
      stepCycle();
      core_done = 1'b0;
      ma = a;
      ml = l;
      foreach (expLen[i]) begin
         checkOutput("cmd_valid", dma.wr_cmd_valid, 1);
         checkOutput("cmd_addr", dma.wr_cmd_addr, expAddr[i]);
         checkOutput("cmd_len", dma.wr_cmd_len, expLen[i]);
         checkOutput("cmd_rd_len", host_rd_len, ml);
         repeat ($urandom_range(0, 3)) begin
            stepCycle();
            checkOutput("cmd_hold", dma.wr_cmd_valid, 1);
         end
         dma.wr_cmd_ready = 1'b1;
         stepCycle();
         dma.wr_cmd_ready = 1'b0;
         checkOutput("wait_valid", dma.wr_cmd_valid, 0);
         repeat ($urandom_range(0, 3)) stepCycle();
         dma.wr_done = 1'b1;
         stepCycle();
         dma.wr_done = 1'b0;
         ma = ma + expLen[i];
         ml = ml - expLen[i];
         checkOutput("prog_rd_addr", host_rd_addr, ma);
         checkOutput("prog_rd_len", host_rd_len, ml);
      end
      checkOutput("job_done", pbs_done, 1);
      checkOutput("job_busy", pbs_busy, 0);
      checkOutput("job_valid", dma.wr_cmd_valid, 0);
      checkOutput("job_bank", core_bank, bank);
      repeat ($urandom_range(0, 2)) begin
         stepCycle();
         checkOutput("done_hold", pbs_done, 1);
      end
      start_pbs = 1'b0;
      stepCycle();
      checkOutput("done_clear", pbs_done, 0);
      stepCycle();
   endtask

   initial begin
      dma.wr_cmd_ready = 1'b0;
      dma.wr_done      = 1'b0;

      // Reset with start already high: must not launch afterwards.
      repeat (3) stepCycle();
      checkIdleZero("reset");
      S_AXI_ARESET = 1'b0;
      repeat (5) begin
         stepCycle();
         checkOutput("no_launch_start", core_start, 0);
         checkOutput("no_launch_busy", pbs_busy, 0);
      end
      start_pbs = 1'b0;
      stepCycle();

      applyStimulus(32'h0000_1000, 32'h0000_2000, 2'd1);
      applyStimulus(32'h0000_0FF0, 32'h0000_0030, 2'd2);
      applyStimulus(32'h0000_4000, 32'h0000_0000, 2'd3);
      applyStimulus(32'hFFFF_FF00, 32'h0000_0200, 2'd0);
      applyStimulus(32'h0000_0001, 32'h0000_1FFF, 2'd2);
      for (int j = 0; j < 10; j++)
         applyStimulus($urandom, $urandom_range(0, 10000), 2'($urandom_range(0, 3)));

      // Abort in RUN.
      launchJob(32'h0000_0200, 32'h0000_0100, 2'd1);
      start_pbs = 1'b0;
      stepCycle();
      checkOutput("abort_run_err", pbs_err, 1);
      checkOutput("abort_run_busy", pbs_busy, 0);
      stepCycle();
      checkOutput("abort_run_idle", pbs_err, 0);

      // core_done and abort together: abort wins.
      launchJob(32'h0000_0300, 32'h0000_0100, 2'd2);
      core_done = 1'b1;
      start_pbs = 1'b0;
      stepCycle();
      core_done = 1'b0;
      checkOutput("race_err", pbs_err, 1);
      checkOutput("race_valid", dma.wr_cmd_valid, 0);
      stepCycle();

      // Ready held low 50 cycles, abort and an illegal wr_done during CMD.
      buildModel(32'h0000_0100, 32'h0000_3000);
      launchJob(32'h0000_0100, 32'h0000_3000, 2'd2);
      core_done = 1'b1;
      stepCycle();
      core_done = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (c == 10) start_pbs = 1'b0;
         if (c == 20) dma.wr_done = 1'b1;
         stepCycle();
         dma.wr_done = 1'b0;
         checkOutput("stall_valid", dma.wr_cmd_valid, 1);
         checkOutput("stall_addr", dma.wr_cmd_addr, expAddr[0]);
         checkOutput("stall_len", dma.wr_cmd_len, expLen[0]);
         checkOutput("stall_rd_len", host_rd_len, 32'h0000_3000);
      end
      dma.wr_cmd_ready = 1'b1;
      stepCycle();
      dma.wr_cmd_ready = 1'b0;
      checkOutput("abort_wait_valid", dma.wr_cmd_valid, 0);
      checkOutput("abort_wait_busy", pbs_busy, 1);
      dma.wr_done = 1'b1;
      stepCycle();
      dma.wr_done = 1'b0;
      checkOutput("abort_burst_err", pbs_err, 1);
      checkOutput("abort_burst_done", pbs_done, 0);
      checkOutput("abort_burst_busy", pbs_busy, 0);
      checkOutput("abort_rd_addr", host_rd_addr, 32'h0000_0100 + expLen[0]);
      checkOutput("abort_rd_len", host_rd_len, 32'h0000_3000 - expLen[0]);
      stepCycle();
      checkOutput("abort_idle_err", pbs_err, 0);
      stepCycle();

      // core_done never arrives.
      launchJob(32'h0000_8000, 32'h0000_0040, 2'd3);
      repeat (TIMEOUT - 1) stepCycle();
      checkOutput("wd_before_err", pbs_err, 0);
      checkOutput("wd_before_busy", pbs_busy, 1);
      stepCycle();
`ifdef TFHE_SEQ_TIMEOUT_EN
      checkOutput("wd_fire_err", pbs_err, 1);
      checkOutput("wd_fire_busy", pbs_busy, 0);
`else
      checkOutput("wd_none_err", pbs_err, 0);
      checkOutput("wd_none_busy", pbs_busy, 1);
`endif
      start_pbs = 1'b0;
      repeat (3) stepCycle();
      checkOutput("wd_end_busy", pbs_busy, 0);
      checkOutput("wd_end_err", pbs_err, 0);

      // Reset while waiting for wr_done, then a stale wr_done.
      launchJob(32'h0000_2000, 32'h0000_0800, 2'd3);
      core_done = 1'b1;
      stepCycle();
      core_done = 1'b0;
      dma.wr_cmd_ready = 1'b1;
      stepCycle();
      dma.wr_cmd_ready = 1'b0;
      checkOutput("pre_reset_busy", pbs_busy, 1);
      S_AXI_ARESET = 1'b1;
      stepCycle();
      checkIdleZero("mid_reset");
      S_AXI_ARESET = 1'b0;
      dma.wr_done  = 1'b1;
      stepCycle();
      dma.wr_done  = 1'b0;
      checkIdleZero("stale_done");
      repeat (3) stepCycle();
      checkIdleZero("post_reset");
      start_pbs = 1'b0;
      stepCycle();

      applyStimulus(32'h0000_5FF8, 32'h0000_0010, 2'd1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
